// File: rtl/div_pkg.sv
// Shared state encoding, default width and helper function for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_ZERO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_FIX  = ST_FIX,
        S_ZERO = ST_ZERO
    } div_state_t;

    // Bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: y = en ? -x : x.
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = en ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/div_iter_param.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, signed or unsigned per request.
// Optional build macro DIV_EARLY_EXIT_EN: short-cut requests whose divisor magnitude exceeds the dividend's.
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             DivStart,
    input  logic             DivSigned,
    input  logic [WIDTH-1:0] Dividendo,
    input  logic [WIDTH-1:0] Divisor,
    output logic             DivBusy,
    output logic             DivFim,
    output logic             DivisaoPorZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = clog2(WIDTH + 1);

    div_state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_mag_q;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             ge;

    logic load;
    logic step;
    logic finish;
    logic zero_fin;
`ifdef DIV_EARLY_EXIT_EN
    logic early_load;
    logic early_pend;
`endif

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .en (DivSigned & Dividendo[WIDTH-1]),
        .x  (Dividendo),
        .y  (a_mag)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .en (DivSigned & Divisor[WIDTH-1]),
        .x  (Divisor),
        .y  (b_mag)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
        .en (neg_q),
        .x  (quo),
        .y  (fix_q)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
        .en (neg_r),
        .x  (rem[WIDTH-1:0]),
        .y  (fix_r)
    );

    // A restore step always leaves rem < divisor, so the top remainder bit is never carried out.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    assign partial = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = partial - {1'b0, b_mag_q};
    assign ge      = (partial >= {1'b0, b_mag_q});
    assign DivBusy = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        zero_fin   = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
        early_load = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (DivStart) begin
                    load = 1'b1;
                    if (b_mag == '0) begin
                        state_next = S_ZERO;
`ifdef DIV_EARLY_EXIT_EN
                    end else if (b_mag > a_mag) begin
                        early_load = 1'b1;
                        state_next = S_FIX;
`endif
                    end else begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
`ifdef DIV_EARLY_EXIT_EN
                // The short-cut spends one extra cycle here so it completes two cycles after start.
                if (!early_pend) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
`else
                finish     = 1'b1;
                state_next = S_IDLE;
`endif
            end
            S_ZERO: begin
                zero_fin   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: operand and work registers are reset too, so a reset mid-division leaves no stale state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            b_mag_q        <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            DivFim         <= 1'b0;
            DivisaoPorZero <= 1'b0;
            Hi             <= '0;
            Lo             <= '0;
`ifdef DIV_EARLY_EXIT_EN
            early_pend     <= 1'b0;
`endif
        end else begin
            DivFim         <= finish | zero_fin;
            DivisaoPorZero <= zero_fin;

            if (load) begin
                cnt     <= CNT_W'(WIDTH);
                rem     <= '0;
                quo     <= a_mag;
                b_mag_q <= b_mag;
                neg_q   <= DivSigned & (Dividendo[WIDTH-1] ^ Divisor[WIDTH-1]);
                neg_r   <= DivSigned & Dividendo[WIDTH-1];
            end

`ifdef DIV_EARLY_EXIT_EN
            if (early_load) begin
                rem        <= {1'b0, a_mag};
                quo        <= '0;
                early_pend <= 1'b1;
            end else if (state == S_FIX) begin
                early_pend <= 1'b0;
            end
`endif

            if (step) begin
                cnt <= cnt - CNT_W'(1);
                rem <= ge ? diff : partial;
                quo <= {quo[WIDTH-2:0], ge};
            end

            if (finish) begin
                Hi <= fix_r;
                Lo <= fix_q;
            end
        end
    end

endmodule

// File: tb/tb_div_iter_param.sv
// Directed self-checking bench for div_iter_param at WIDTH=32 and WIDTH=8.
module tb_div_iter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, sgn;
    logic [31:0] a, b;
    logic        busy, fim, dz;
    logic [31:0] hi, lo;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, fim8, dz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 33;
`endif

    div_iter_param #(.WIDTH(32)) dut (
        .Clk(clk), .Reset(rst), .DivStart(start), .DivSigned(sgn),
        .Dividendo(a), .Divisor(b), .DivBusy(busy), .DivFim(fim),
        .DivisaoPorZero(dz), .Hi(hi), .Lo(lo)
    );

    div_iter_param #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .DivStart(start8), .DivSigned(sgn8),
        .Dividendo(a8), .Divisor(b8), .DivBusy(busy8), .DivFim(fim8),
        .DivisaoPorZero(dz8), .Hi(hi8), .Lo(lo8)
    );

    // Starts one 32-bit request and returns at the falling edge where DivFim is seen (or a 100-cycle bound).
    task automatic run_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                           output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; sgn = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (fim !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_div8(input logic s, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (fim8 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fim !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL reset_pulses got fim=%b dz=%b want 0/0", fim, dz); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got hi=%h lo=%h want 0/0", hi, lo); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, nb;
        run_div(1'b0, 32'd100, 32'd7, lat, nb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL u100_7_latency got %0d want 33", lat); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL u100_7_busy_cycles got %0d want 33", nb); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14 || dz !== 1'b0) begin errors++; $display("FAIL u100_7 got hi=%h lo=%h dz=%b want 2/e/0", hi, lo, dz); end
        @(negedge clk);
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL fim_one_cycle got %b want 0", fim); end

        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, nb);
        checks++; if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL umax_1 got hi=%h lo=%h want 0/ffffffff", hi, lo); end

        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, lat, nb);
        checks++; if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL u_big_2 got hi=%h lo=%h want 1/7ffffffc", hi, lo); end

        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        checks++; if (hi !== 32'h8000_0000 || lo !== 32'h0) begin errors++; $display("FAIL u_small_big got hi=%h lo=%h want 80000000/0", hi, lo); end
        checks++; if (lat !== EARLY_LAT) begin errors++; $display("FAIL u_small_big_latency got %0d want %0d", lat, EARLY_LAT); end

        run_div(1'b0, 32'd5, 32'd9, lat, nb);
        checks++; if (hi !== 32'd5 || lo !== 32'd0 || lat !== EARLY_LAT) begin errors++; $display("FAIL u5_9 got hi=%h lo=%h lat=%0d want 5/0/%0d", hi, lo, lat, EARLY_LAT); end
    endtask

    task automatic test_signed();
        int lat, nb;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, nb);
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s_m7_2 got hi=%h lo=%h want ffffffff/fffffffd", hi, lo); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL s_m7_2_latency got %0d want 33", lat); end

        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, nb);
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s_7_m2 got hi=%h lo=%h want 1/fffffffd", hi, lo); end

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        checks++; if (hi !== 32'h0 || lo !== 32'h8000_0000 || dz !== 1'b0) begin errors++; $display("FAIL s_min_m1 got hi=%h lo=%h dz=%b want 0/80000000/0", hi, lo, dz); end

        run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat, nb);
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'd3) begin errors++; $display("FAIL s_m7_m2 got hi=%h lo=%h want ffffffff/3", hi, lo); end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_div(1'b1, 32'd1234, 32'd0, lat, nb);
        checks++; if (lat !== 1 || nb !== 1) begin errors++; $display("FAIL dz_latency got lat=%0d busy=%0d want 1/1", lat, nb); end
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'd3) begin errors++; $display("FAIL dz_hold got hi=%h lo=%h want ffffffff/3", hi, lo); end
        @(negedge clk);
        checks++; if (fim !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL dz_fall got fim=%b dz=%b want 0/0", fim, dz); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, seen;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || fim !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL mid_reset got busy=%b fim=%b hi=%h lo=%h want all 0", busy, fim, hi, lo);
        end
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (fim === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_fim got %0d pulses want 0", seen); end
        run_div(1'b0, 32'd1000, 32'd10, lat, nb);
        checks++; if (hi !== 32'd0 || lo !== 32'd100 || lat !== 33) begin errors++; $display("FAIL after_reset got hi=%h lo=%h lat=%0d want 0/64/33", hi, lo, lat); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        start = 1'b1; sgn = 1'b1; a = 32'd50; b = 32'd5;
        @(negedge clk); n++;
        start = 1'b0;
        while (fim !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n !== 33 || hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL busy_ignore got n=%0d hi=%h lo=%h want 33/2/e", n, hi, lo); end

        start = 1'b1; sgn = 1'b0; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (fim !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n !== 33 || hi !== 32'd0 || lo !== 32'd10) begin errors++; $display("FAIL back_to_back got n=%0d hi=%h lo=%h want 33/0/a", n, hi, lo); end
    endtask

    task automatic test_width8();
        int lat;
        run_div8(1'b1, 8'h80, 8'h03, lat);
        checks++; if (hi8 !== 8'hFE || lo8 !== 8'hD6 || lat !== 9) begin errors++; $display("FAIL w8_min_3 got hi=%h lo=%h lat=%0d want fe/d6/9", hi8, lo8, lat); end
        run_div8(1'b1, 8'h80, 8'hFF, lat);
        checks++; if (hi8 !== 8'h00 || lo8 !== 8'h80 || dz8 !== 1'b0) begin errors++; $display("FAIL w8_min_m1 got hi=%h lo=%h dz=%b want 0/80/0", hi8, lo8, dz8); end
        run_div8(1'b1, 8'd100, 8'hF9, lat);
        checks++; if (hi8 !== 8'h02 || lo8 !== 8'hF2) begin errors++; $display("FAIL w8_100_m7 got hi=%h lo=%h want 02/f2", hi8, lo8); end
        run_div8(1'b0, 8'hFF, 8'h10, lat);
        checks++; if (hi8 !== 8'h0F || lo8 !== 8'h0F || lat !== 9) begin errors++; $display("FAIL w8_255_16 got hi=%h lo=%h lat=%0d want 0f/0f/9", hi8, lo8, lat); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
